// File: rtl/program_loader.sv
// Boot loader: receives a framed LE image over valid/ready bytes, writes 32-bit words to imem,
// holds the CPU in reset until the trailing XOR checksum verifies. Write strobe lags its byte by one cycle.
module program_loader #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          MAX_WORDS    = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_address,
  output logic [31:0] imem_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_HEADER,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] word_q, word_d;
  logic [31:0] idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        fire;
  logic [31:0] hdr_shift;
  logic [31:0] word_shift;

  assign rx_ready   = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign fire       = rx_valid && rx_ready;
  // Bytes arrive LSB first, so shifting in from the top leaves the word in LE order after four bytes.
  assign hdr_shift  = {rx_data, count_q[31:8]};
  assign word_shift = {rx_data, word_q[31:8]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    word_d      = word_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_HEADER: begin
        if (fire) begin
          count_d = hdr_shift;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (hdr_shift == 32'd0) begin
              state_d = S_CHECK;
            end else if (hdr_shift > 32'(MAX_WORDS)) begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          word_d = word_shift;
          csum_d = csum_q ^ rx_data;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            we_d   = 1'b1;
            data_d = word_shift;
            addr_d = BASE_ADDRESS + {idx_q[29:0], 2'b00};
            idx_d  = idx_q + 32'd1;
            if (idx_q + 32'd1 == count_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (fire) begin
          if (rx_data == csum_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_HEADER;
      cnt_q       <= 2'd0;
      count_q     <= 32'd0;
      word_q      <= 32'd0;
      idx_q       <= 32'd0;
      csum_q      <= 8'd0;
      we_q        <= 1'b0;
      addr_q      <= BASE_ADDRESS;
      data_q      <= 32'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_address = addr_q;
  assign imem_data    = data_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames plus random frames scored against a frame-parsing model.
module tb_program_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        va, vb;
  logic [7:0]  da, db;
  logic        rdy_a, rdy_b, we_a, we_b;
  logic [31:0] addr_a, addr_b, dat_a, dat_b;
  logic        cpur_a, cpur_b, done_a, done_b, err_a, err_b;

  int n_asrt = 0;
  int n_fail = 0;

  logic [63:0] wa[$];
  logic [63:0] wb[$];
  logic [7:0]  frame[$];

  program_loader u_a (
    .clock(clock), .reset(reset), .rx_valid(va), .rx_data(da), .rx_ready(rdy_a),
    .imem_we(we_a), .imem_address(addr_a), .imem_data(dat_a),
    .cpu_reset(cpur_a), .done(done_a), .error(err_a)
  );

  program_loader #(.BASE_ADDRESS(32'h0000_0100), .MAX_WORDS(256)) u_b (
    .clock(clock), .reset(reset), .rx_valid(vb), .rx_data(db), .rx_ready(rdy_b),
    .imem_we(we_b), .imem_address(addr_b), .imem_data(dat_b),
    .cpu_reset(cpur_b), .done(done_b), .error(err_b)
  );

  always @(negedge clock) begin
    if (we_a === 1'b1) wa.push_back({addr_a, dat_a});
    if (we_b === 1'b1) wb.push_back({addr_b, dat_b});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel != 0) ? rdy_b : rdy_a;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel != 0) begin vb = v; db = d; end
    else begin va = v; da = d; end
  endtask

  // Entered and left at a falling edge; returns once the byte has been taken.
  task automatic send(input int sel, input logic [7:0] b, input int gap);
    int k;
    if (gap > 0) begin
      drive(sel, 1'b0, 8'h00);
      repeat (gap) @(negedge clock);
    end
    drive(sel, 1'b1, b);
    k = 0;
    while (rdy(sel) !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (k == 20) chk("send_timeout", 64'd0, 64'd1);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1'b1, 8'($urandom));
    drive(1, 1'b1, 8'($urandom));
    @(negedge clock);
    chk("rst_we_a",    {63'd0, we_a},   64'd0);
    chk("rst_addr_a",  {32'd0, addr_a}, 64'h0);
    chk("rst_data_a",  {32'd0, dat_a},  64'h0);
    chk("rst_flags_a", {60'd0, cpur_a, done_a, err_a, rdy_a}, 64'b1001);
    chk("rst_addr_b",  {32'd0, addr_b}, 64'h100);
    chk("rst_flags_b", {60'd0, cpur_b, done_b, err_b, rdy_b}, 64'b1001);
    reset = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    @(negedge clock);
  endtask

  // gap < 0 selects a random 0..3 idle cycles before each byte.
  task automatic run_frame(input int sel, input int gap, input string name);
    logic [31:0] base, n, word;
    logic [7:0]  cs;
    logic [63:0] exp_w[$];
    logic [63:0] got[$];
    int consumed, nw;
    logic exp_done, exp_err, fd, fe, fc, fr;

    base = (sel != 0) ? 32'h100 : 32'h0;
    n = {frame[3], frame[2], frame[1], frame[0]};
    exp_w = {};
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n > 32'd256) begin
      consumed = 4;
      exp_err  = 1'b1;
    end else begin
      cs = 8'h00;
      for (int w = 0; w < int'(n); w++) begin
        word = {frame[4+4*w+3], frame[4+4*w+2], frame[4+4*w+1], frame[4+4*w]};
        cs = cs ^ word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
        exp_w.push_back({base + 32'(4 * w), word});
      end
      consumed = 4 + 4 * int'(n) + 1;
      exp_done = (frame[consumed-1] == cs);
      exp_err  = !exp_done;
    end

    wa = {};
    wb = {};
    for (int i = 0; i < consumed; i++)
      send(sel, frame[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
    drive(sel, 1'b0, 8'h00);
    repeat (3) @(negedge clock);

    got = (sel != 0) ? wb : wa;
    chk({name, "_wcount"}, 64'(got.size()), 64'(exp_w.size()));
    nw = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
    for (int i = 0; i < nw; i++) chk({name, "_write"}, got[i], exp_w[i]);
    fd = (sel != 0) ? done_b : done_a;
    fe = (sel != 0) ? err_b  : err_a;
    fc = (sel != 0) ? cpur_b : cpur_a;
    fr = rdy(sel);
    chk({name, "_done"},  {63'd0, fd}, {63'd0, exp_done});
    chk({name, "_error"}, {63'd0, fe}, {63'd0, exp_err});
    chk({name, "_cpurst"}, {63'd0, fc}, {63'd0, !exp_done});
    chk({name, "_ready"}, {63'd0, fr}, 64'd0);

    // A stray byte in a terminal state must be ignored.
    drive(sel, 1'b1, 8'($urandom));
    repeat (4) @(negedge clock);
    got = (sel != 0) ? wb : wa;
    chk({name, "_stray_w"}, 64'(got.size()), 64'(exp_w.size()));
    chk({name, "_stray_f"},
        {61'd0, (sel != 0) ? done_b : done_a, (sel != 0) ? err_b : err_a, rdy(sel)},
        {61'd0, exp_done, exp_err, 1'b0});
    drive(sel, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] n, w;
    logic [7:0]  cs;
    int sel;

    reset = 1'b1;
    va = 1'b0; vb = 1'b0; da = 8'h00; db = 8'h00;
    repeat (2) @(negedge clock);
    do_reset();

    frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
              8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
    run_frame(0, 0, "nominal");

    do_reset();
    frame[12] = 8'h62;
    run_frame(0, 0, "badsum");

    do_reset();
    frame = '{8'h01, 8'h01, 8'h00, 8'h00};
    run_frame(0, 0, "oversize");

    do_reset();
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(0, 0, "empty_ok");

    do_reset();
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    run_frame(0, 0, "empty_bad");

    do_reset();
    frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    run_frame(1, 3, "stalled");

    // Reset in the middle of word 0; the partial word must never be written.
    do_reset();
    wa = {};
    frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    for (int i = 0; i < 6; i++) send(0, frame[i], 0);
    drive(0, 1'b0, 8'h00);
    repeat (2) @(negedge clock);
    chk("midrst_nowrite", 64'(wa.size()), 64'd0);
    do_reset();
    chk("midrst_nowrite2", 64'(wa.size()), 64'd0);
    frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
              8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
    run_frame(0, 0, "after_rst");

    // Largest legal count, streamed back-to-back.
    do_reset();
    frame = '{8'h00, 8'h01, 8'h00, 8'h00};
    cs = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      frame.push_back(8'($urandom));
      cs = cs ^ frame[frame.size()-1];
    end
    frame.push_back(cs);
    run_frame(0, 0, "max_words");

    for (int it = 0; it < 12; it++) begin
      sel = it % 2;
      n = 32'($urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0) n = 32'd257 + 32'($urandom_range(0, 100000));
      frame = {};
      for (int b = 0; b < 4; b++) frame.push_back(n[8*b +: 8]);
      if (n <= 32'd256) begin
        cs = 8'h00;
        for (int i = 0; i < int'(n); i++) begin
          w = $urandom;
          for (int b = 0; b < 4; b++) begin
            frame.push_back(w[8*b +: 8]);
            cs = cs ^ w[8*b +: 8];
          end
        end
        if ($urandom_range(0, 2) == 0) cs = cs ^ 8'($urandom_range(1, 255));
        frame.push_back(cs);
      end
      do_reset();
      run_frame(sel, -1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time byte-stream responder that fills instruction memory. The CPU is the reader of that memory; this block is its writer.
- Receives a framed little-endian image over a valid/ready byte interface and writes 32-bit words sequentially from BASE_ADDRESS.
- Holds the CPU in reset while loading. Releases the CPU only after the image checksum verifies.

Parameters:
BASE_ADDRESS, 32'h0000_0000, byte address of the first instruction word written
MAX_WORDS, 256, largest accepted word count; a larger header count is an error

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high; aborts any load
rx_valid  input  1  rx_data holds a byte
rx_data  input  8  incoming byte
rx_ready  output  1  block accepts a byte; combinational from state
imem_we  output  1  one-cycle instruction-memory write strobe
imem_address  output  32  word-aligned write address
imem_data  output  32  write data
cpu_reset  output  1  drives the CPU reset; high until a successful load
done  output  1  load complete and verified; sticky
error  output  1  load failed; sticky

Behaviour:
- Frame format:
  - 4-byte LE word count N.
  - N×4 payload bytes, each word LE.
  - 1 checksum byte = XOR of all payload bytes. Header bytes are excluded.
- Handshake: a byte transfers on a rising edge with rx_valid && rx_ready. rx_data is ignored otherwise. rx_valid may drop at any time; the block simply waits.
- States: HEADER, DATA, CHECK, DONE, ERROR. rx_ready=1 in HEADER/DATA/CHECK and 0 in DONE/ERROR.
- Reset (every cycle reset=1):
  - state=HEADER, byte counter=0, word index=0, checksum accumulator=0.
  - imem_we=0, imem_address=BASE_ADDRESS, imem_data=0.
  - cpu_reset=1, done=0, error=0.
- HEADER:
  - Shift bytes into the count register, LE.
  - On the 4th byte: N=0 → CHECK; N>MAX_WORDS → ERROR; else → DATA.
- DATA:
  - 2-bit byte counter assembles the word LE; each byte is XORed into the accumulator.
  - The cycle after the 4th byte's handshake: imem_we=1 for exactly one cycle, imem_data=assembled word, imem_address=BASE_ADDRESS+4×index.
  - Index increments after each word. After word N-1 the state moves to CHECK.
  - rx_ready stays 1 during the write cycle, so a back-to-back byte stream never stalls.
  - Address arithmetic is 32-bit modulo; no range check beyond MAX_WORDS.
- CHECK:
  - Accept one byte and compare it to the accumulator.
  - Match → DONE: done=1 and cpu_reset=0, both registered, visible the cycle after the handshake.
  - Mismatch → ERROR: error=1; cpu_reset stays 1.
- DONE/ERROR: terminal until reset. No writes. Bytes presented are not accepted.
- Simultaneous events:
  - The final-word write strobe and the checksum byte may share a cycle; both take effect.
  - Reset wins over any handshake in the same cycle.
- Reset mid-load:
  - A partial word is discarded and never written.
  - imem_we=0 on the reset cycle.
  - Memory contents written so far are not cleared.
  - A fresh full frame must then load correctly.
- imem_we is never asserted outside DATA-derived write cycles. done and error are never both 1.

Test Plan:
- Nominal load:
  - Stimulus: bytes 02 00 00 00 | 93 00 50 00 | 33 81 10 00 | 61, streamed back-to-back.
  - Required: two write strobes, addr 0x0 data 0x00500093, then addr 0x4 data 0x00108133. Then done=1, cpu_reset=0, error=0, rx_ready=0.
- Bad checksum:
  - Stimulus: same frame with checksum 0x62.
  - Required: both writes still occur, then error=1, cpu_reset=1, done=0. A further byte with rx_valid=1 is not accepted.
- Oversize count:
  - Stimulus: header 01 01 00 00 (N=257), MAX_WORDS=256.
  - Required: ERROR right after the 4th header byte; zero imem_we pulses; error=1.
- Empty image:
  - Stimulus: header 00 00 00 00 then checksum 00.
  - Required: no writes; done=1, cpu_reset=0. The same header with checksum 0x01 gives error=1 instead.
- Stalled source and parameter:
  - Stimulus: BASE_ADDRESS=0x100; frame 01 00 00 00 | EF BE AD DE | 22, with rx_valid deasserted for 3 cycles between every byte.
  - Required: a single write, addr 0x100 data 0xDEADBEEF; done=1.
- Reset mid-DATA:
  - Stimulus: send the header 02 00 00 00 and 2 bytes of word 0, then pulse reset for 1 cycle.
  - Required: no write occurs; outputs return to reset values; a subsequent full nominal frame produces the nominal result exactly.
